// File: rtl/alu_cmd_sequencer.sv
// Command FIFO + issue FSM driving an external combinational ALU; responses return in order.
// Optional macro ALU_FLAGS_EN adds registered rsp_zero / rsp_carry outputs.
module alu_cmd_sequencer #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [2:0]       cmd_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [2:0]       rsp_op,
`ifdef ALU_FLAGS_EN
  output logic             rsp_zero,
  output logic             rsp_carry,
`endif
  output logic             busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullCnt = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e           r_state;
  logic [WIDTH-1:0] r_fifo_a [DEPTH];
  logic [WIDTH-1:0] r_fifo_b [DEPTH];
  logic [2:0]       r_fifo_op [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [2:0]       r_alu_ctrl;
  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_result;
  logic [2:0]       r_rsp_op;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_count == FullCnt);
  assign w_empty = (r_count == '0);
  assign w_push  = cmd_valid && !w_full;
  // Pop happens exactly when the FSM loads the ALU registers.
  assign w_pop   = !w_empty &&
                   ((r_state == StIdle) || ((r_state == StResp) && r_rsp_valid && rsp_ready));

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_a[r_wr_ptr]  <= cmd_a;
      r_fifo_b[r_wr_ptr]  <= cmd_b;
      r_fifo_op[r_wr_ptr] <= cmd_op;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

`ifdef ALU_FLAGS_EN
  logic             r_rsp_zero;
  logic             r_rsp_carry;
  logic [WIDTH:0]   w_sum;
  logic             w_carry;

  assign w_sum = {1'b0, r_alu_a} + {1'b0, r_alu_b};

  always_comb begin
    w_carry = 1'b0;
    if (r_alu_ctrl == 3'b010)      w_carry = w_sum[WIDTH];
    else if (r_alu_ctrl == 3'b011) w_carry = (r_alu_a < r_alu_b);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_zero  <= 1'b0;
      r_rsp_carry <= 1'b0;
    end else if (r_state == StIssue) begin
      r_rsp_zero  <= (alu_result == '0);
      r_rsp_carry <= w_carry;
    end
  end

  assign rsp_zero  = r_rsp_zero;
  assign rsp_carry = r_rsp_carry;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_ctrl   <= 3'b000;
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_op     <= 3'b000;
    end else begin
      if (w_pop) begin
        r_alu_a    <= r_fifo_a[r_rd_ptr];
        r_alu_b    <= r_fifo_b[r_rd_ptr];
        r_alu_ctrl <= r_fifo_op[r_rd_ptr];
      end
      unique case (r_state)
        StIdle: begin
          if (!w_empty) r_state <= StIssue;
        end
        StIssue: begin
          r_rsp_result <= alu_result;
          r_rsp_op     <= r_alu_ctrl;
          r_rsp_valid  <= 1'b1;
          r_state      <= StResp;
        end
        StResp: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= w_empty ? StIdle : StIssue;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign cmd_ready  = !w_full;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_ctrl   = r_alu_ctrl;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_rsp_result;
  assign rsp_op     = r_rsp_op;
  assign busy       = (r_state != StIdle) || !w_empty;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed + random bench for alu_cmd_sequencer with an in-order scoreboard and a behavioural ALU.
module tb_alu_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_a = '0;
  logic [3:0] cmd_b = '0;
  logic [2:0] cmd_op = '0;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_ctrl;
  logic [3:0] alu_result;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [3:0] rsp_result;
  logic [2:0] rsp_op;
  logic       busy;
`ifdef ALU_FLAGS_EN
  logic       rsp_zero;
  logic       rsp_carry;
`endif

  typedef struct {
    logic [3:0] res;
    logic [2:0] op;
    logic       z;
    logic       c;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] lit[$];
  int         hs_times[$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;

  always #5 clk = ~clk;

  function automatic logic [3:0] ref_alu(input logic [3:0] a, input logic [3:0] b,
                                         input logic [2:0] op);
    int ia, ib, r;
    ia = int'(a);
    ib = int'(b);
    case (op)
      3'd0:    r = ia & ib;
      3'd1:    r = ia | ib;
      3'd2:    r = ia + ib;
      3'd3:    r = ia - ib + 16;
      3'd4:    r = ia ^ ib;
      3'd5:    r = 15 - (ia | ib);
      3'd6:    r = 15 - (ia & ib);
      default: r = 15 - ia;
    endcase
    return 4'(r % 16);
  endfunction

  // External combinational ALU attached to the sequencer.
  assign alu_result = ref_alu(alu_a, alu_b, alu_ctrl);

  alu_cmd_sequencer #(.WIDTH(4), .DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_op     (cmd_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_op     (rsp_op),
`ifdef ALU_FLAGS_EN
    .rsp_zero   (rsp_zero),
    .rsp_carry  (rsp_carry),
`endif
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: score handshakes seen before the edge, then sample #1 after it.
  task automatic cycle();
    logic acc, hs, stall;
    logic [3:0] pr;
    logic [2:0] po;
    exp_t e;
    int ia, ib;
    acc   = cmd_valid && cmd_ready && rst_n;
    hs    = rsp_valid && rsp_ready;
    stall = rsp_valid && !rsp_ready && rst_n;
    pr    = rsp_result;
    po    = rsp_op;
    if (hs) begin
      hs_times.push_back(cyc);
      if (sb.size() == 0) begin
        chk("spurious_rsp", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("rsp_result", rsp_result, e.res);
        chk("rsp_op", rsp_op, e.op);
`ifdef ALU_FLAGS_EN
        chk("rsp_zero", rsp_zero, e.z);
        chk("rsp_carry", rsp_carry, e.c);
`endif
      end
      if (lit.size() > 0) chk("rsp_literal", rsp_result, lit.pop_front());
    end
    if (acc) begin
      ia    = int'(cmd_a);
      ib    = int'(cmd_b);
      e.res = ref_alu(cmd_a, cmd_b, cmd_op);
      e.op  = cmd_op;
      e.z   = (e.res == 4'd0);
      e.c   = (cmd_op == 3'd2) ? (ia + ib > 15) : (cmd_op == 3'd3) ? (ia < ib) : 1'b0;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (stall && rst_n) begin
      chk("stall_valid", rsp_valid, 1);
      chk("stall_result", rsp_result, pr);
      chk("stall_op", rsp_op, po);
    end
  endtask

  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    int k;
    logic took;
    k = 0;
    cmd_a = a;
    cmd_b = b;
    cmd_op = op;
    cmd_valid = 1'b1;
    do begin
      took = cmd_ready;
      cycle();
      k++;
    end while (!took && k < 50);
    chk("send_accept", took, 1);
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    while (sb.size() != 0 && k < 200) begin
      cycle();
      k++;
    end
    chk({tag, "_drained"}, sb.size(), 0);
    chk({tag, "_busy_low"}, busy, 0);
  endtask

  task automatic single(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                        input logic [3:0] res, input logic z, input logic c);
    rsp_ready = 1'b1;
    cmd_a = a;
    cmd_b = b;
    cmd_op = op;
    cmd_valid = 1'b1;
    chk("single_ready", cmd_ready, 1);
    cycle();
    cmd_valid = 1'b0;
    chk("lat_k", rsp_valid, 0);
    cycle();
    chk("lat_k1", rsp_valid, 0);
    cycle();
    chk("lat_k2", rsp_valid, 1);
    chk("single_result", rsp_result, res);
    chk("single_op", rsp_op, op);
`ifdef ALU_FLAGS_EN
    chk("single_zero", rsp_zero, z);
    chk("single_carry", rsp_carry, c);
`else
    if (z === 1'bx || c === 1'bx) chk("flag_args", 0, 1);
`endif
    cycle();
    chk("single_busy", busy, 0);
  endtask

  initial begin
    // Reset values
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_ctrl", alu_ctrl, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_rsp_op", rsp_op, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset while a response is pending
    rsp_ready = 1'b0;
    send(4'd2, 4'd5, 3'd3);
    cycle();
    cycle();
    chk("t1_in_resp", rsp_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("t1_rsp_valid", rsp_valid, 0);
    chk("t1_cmd_ready", cmd_ready, 1);
    chk("t1_alu_ctrl", alu_ctrl, 0);
    chk("t1_busy", busy, 0);
    sb.delete();
    lit.delete();
    cycle();
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("t1_no_rsp", rsp_valid, 0);
    end

    // Single ADD and wrapping SUB
    single(4'd3, 4'd5, 3'd2, 4'd8, 1'b0, 1'b0);
    single(4'd2, 4'd5, 3'd3, 4'hD, 1'b0, 1'b1);

    // Sweep all ops on A/6
    lit = '{4'h2, 4'hE, 4'h0, 4'h4, 4'hC, 4'h1, 4'hD, 4'h5};
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) send(4'hA, 4'h6, 3'(i));
    drain("t4");
    chk("t4_lit_used", lit.size(), 0);

    // Backpressure: 1 in flight + 4 queued, 6th refused
    rsp_ready = 1'b0;
    lit = '{4'h2, 4'hE, 4'h0, 4'h4, 4'hC};
    cmd_a = 4'hA;
    cmd_b = 4'h6;
    for (int i = 0; i < 6; i++) begin
      cmd_op = 3'(i);
      cmd_valid = 1'b1;
      chk("t5_cmd_ready", cmd_ready, (i < 5) ? 1 : 0);
      cycle();
    end
    cmd_valid = 1'b0;
    repeat (3) cycle();
    chk("t5_valid_held", rsp_valid, 1);
    chk("t5_queued", sb.size(), 5);
    drain("t5");
    chk("t5_lit_used", lit.size(), 0);

    // Streaming: one response per 2 cycles
    hs_times.delete();
    lit = '{4'h0, 4'hF, 4'hF, 4'h3};
    rsp_ready = 1'b1;
    send(4'hC, 4'h3, 3'd0);
    send(4'hC, 4'h3, 3'd1);
    send(4'hC, 4'h3, 3'd4);
    send(4'hC, 4'h3, 3'd7);
    drain("t6");
    chk("t6_rsp_count", hs_times.size(), 4);
    for (int i = 1; i < hs_times.size(); i++) chk("t6_spacing", hs_times[i] - hs_times[i-1], 2);

    // Random traffic against the scoreboard
    for (int i = 0; i < 400; i++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_a     = 4'($urandom_range(0, 15));
      cmd_b     = 4'($urandom_range(0, 15));
      cmd_op    = 3'($urandom_range(0, 7));
      rsp_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    drain("rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Initiator/driver side of the 4-bit ALU interface.
- Accepts ALU commands (A, B, op) through a valid/ready input channel and buffers them in a small FIFO.
- Issues each command to an external combinational ALU instance through registered operand/control ports, then captures the ALU result.
- Returns the result on a valid/ready response channel, strictly in command order.

Parameters:
WIDTH, 4, operand/result width; must match the attached ALU.
DEPTH, 4, command FIFO depth; power of two, >= 2.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
cmd_valid  input  1  command present.
cmd_ready  output  1  command FIFO can accept (= not full).
cmd_a  input  WIDTH  operand A.
cmd_b  input  WIDTH  operand B.
cmd_op  input  3  ALU control code (000 AND, 001 OR, 010 ADD, 011 SUB, 100 XOR, 101 NOR, 110 NAND, 111 NOT A).
alu_a  output  WIDTH  registered operand A to ALU.
alu_b  output  WIDTH  registered operand B to ALU.
alu_ctrl  output  3  registered control code to ALU.
alu_result  input  WIDTH  combinational ALU result.
rsp_valid  output  1  response present.
rsp_ready  input  1  consumer accepts response.
rsp_result  output  WIDTH  captured ALU result.
rsp_op  output  3  op code of the response.
busy  output  1  FIFO non-empty or FSM not IDLE.

Behaviour:
- Clock and reset: single clock clk; rst_n is asynchronous and active-low.
- Reset values:
  - alu_a = alu_b = 0, alu_ctrl = 000.
  - rsp_valid = 0, rsp_result = 0, rsp_op = 000.
  - FIFO empty; cmd_ready = 1; busy = 0; FSM in IDLE.
  - Reset mid-operation discards all queued and in-flight commands. No response is produced for them.
- Input handshake:
  - Push on any rising edge where cmd_valid && cmd_ready.
  - cmd_ready = !full, combinational from the FIFO count.
  - Push and pop on the same edge leave the count unchanged.
  - Push is never accepted while full.
- FSM, states IDLE, ISSUE, RESP:
  - IDLE: if FIFO non-empty, pop head and load alu_a/alu_b/alu_ctrl, then go to ISSUE. Otherwise stay.
  - ISSUE: one cycle for the ALU to settle. On the next edge, rsp_result <= alu_result, rsp_op <= alu_ctrl, rsp_valid <= 1, then go to RESP.
  - RESP: hold rsp_* stable while rsp_valid && !rsp_ready. On the handshake edge:
    - if FIFO non-empty, pop and load ALU regs in that same edge, rsp_valid <= 0, go to ISSUE;
    - otherwise rsp_valid <= 0, go to IDLE.
  - alu_* retain their last value outside of a load.
- Latency:
  - Command accepted at edge k into an empty, idle block: popped at k+1, rsp_valid high after edge k+2.
  - Sustained throughput is one response per 2 cycles when rsp_ready = 1.
- Arithmetic: all results are modulo 2^WIDTH; ADD/SUB wrap silently. The block never alters alu_result.
- Capacity: up to DEPTH queued commands plus one in flight (ISSUE or RESP). cmd_ready falls when DEPTH entries are queued.
- busy = (state != IDLE) || !empty.

Optional Feature:
- Macro: ALU_FLAGS_EN.
- When defined, add two outputs, registered alongside rsp_result and reset to 0:
  - rsp_zero (1 bit): rsp_result == 0.
  - rsp_carry (1 bit): computed internally from alu_a/alu_b, not from the ALU.
    - op 010: carry-out of alu_a + alu_b.
    - op 011: borrow, i.e. alu_a < alu_b unsigned.
    - all other ops: 0.
- When undefined, these ports and their logic are absent. All other behaviour is identical.

Test Plan:
1. Reset: push SUB 2,5; assert rst_n = 0 while in RESP -> rsp_valid = 0, cmd_ready = 1, alu_ctrl = 000, busy = 0 immediately; no response appears after release.
2. Single ADD, A = 3, B = 5, op = 010, rsp_ready = 1 -> rsp_valid rises 2 edges after accept, rsp_result = 8, rsp_op = 010.
3. Wrap: SUB A = 2, B = 5 -> rsp_result = 4'hD; with ALU_FLAGS_EN, rsp_carry = 1 and rsp_zero = 0.
4. Sweep all 8 ops with A = 4'hA, B = 4'h6 -> results 2, E, 0, 4, C, 1, D, 5 in order. With flags, the ADD response shows rsp_carry = 1 and rsp_zero = 1.
5. Backpressure: hold rsp_ready = 0 and offer 6 commands back-to-back -> 5 accepted (1 in flight + 4 queued); cmd_ready = 0 on the 6th; rsp_* stable. After releasing rsp_ready, all 5 responses arrive in order.
6. Streaming with rsp_ready = 1: AND, OR, XOR, NOT on 4'hC/4'h3 -> responses 0, F, F, 3, spaced every 2 cycles, with busy dropping one cycle after the last handshake.
